// File: rtl/jtcps_busctl_if.sv
// CPU-side bus bundle for jtcps_busctl: 68000 strobes, channel handshakes and interrupt lines.
// The master modport is the CPU/system side; the slave modport is the bus controller.
interface jtcps_busctl_if #(
   parameter int NCH  = 2,
   parameter int NINT = 2
);
   logic            cen;
   logic            cenb;
   logic            as_n;
   logic [2:0]      fc;
   logic [2:0]      alvl;
   logic [NCH-1:0]  cs;
   logic [NCH-1:0]  ok;
   logic [NINT-1:0] irq;
   logic            int_en;
   logic            dtack_n;
   logic            vpa_n;
   logic            berr_n;
   logic [2:0]      ipl_n;

   modport master (
      output cen, cenb, as_n, fc, alvl, cs, ok, irq, int_en,
      input  dtack_n, vpa_n, berr_n, ipl_n
   );

   modport slave (
      input  cen, cenb, as_n, fc, alvl, cs, ok, irq, int_en,
      output dtack_n, vpa_n, berr_n, ipl_n
   );
endinterface

// File: rtl/jtcps_busctl.sv
// 68000 bus controller: DTACKn wait-state generation, autovectored interrupt encoding and,
// with JTCPS_BUSTIMEOUT_EN defined, a bus-timeout that raises BERRn.
module jtcps_busctl #(
   parameter int NCH  = 2,
   parameter int WAIT = 0,
   parameter int NINT = 2,
   parameter int TOUT = 255
) (
   input  logic           clk,
   input  logic           rst,
   jtcps_busctl_if.slave  bus
);
   localparam logic [3:0] WAIT_L = 4'(WAIT);
`ifdef JTCPS_BUSTIMEOUT_EN
   localparam logic [7:0] TOUT_L = 8'(TOUT);
`endif

   typedef enum logic [2:0] {
      ST_HOLD,   // ASn must be seen high before a new cycle may start
      ST_IDLE,
      ST_WAIT,
      ST_ACK,
      ST_BERR
   } state_t;

   state_t     state_q;
   logic [3:0] wait_q;
   logic       dtack_n_q;
   logic       ready;
   logic       iack;
   logic       tout_hit;

   assign ready = &(bus.ok | ~bus.cs);
   assign iack  = (bus.fc == 3'b111) && !bus.as_n;

`ifdef JTCPS_BUSTIMEOUT_EN
   logic [7:0] tout_q;
   logic       berr_n_q;
   assign tout_hit = (tout_q + 8'd1) == TOUT_L;
`else
   assign tout_hit = 1'b0;
`endif

   // NOTE: the async reset forces every registered output idle immediately, even mid-cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= ST_HOLD;
         wait_q    <= '0;
         dtack_n_q <= 1'b1;
`ifdef JTCPS_BUSTIMEOUT_EN
         tout_q    <= '0;
         berr_n_q  <= 1'b1;
`endif
      end else if (bus.cenb) begin
         case (state_q)
            ST_HOLD: if (bus.as_n) state_q <= ST_IDLE;
            ST_IDLE: if (!bus.as_n) begin
               wait_q <= WAIT_L;
`ifdef JTCPS_BUSTIMEOUT_EN
               tout_q <= 8'd1;   // the start cenb is the first one counted
`endif
               if (iack)                           state_q <= ST_HOLD;
               else if (WAIT_L == 4'd0 && ready) begin
                  state_q   <= ST_ACK;
                  dtack_n_q <= 1'b0;
               end else                            state_q <= ST_WAIT;
            end
            ST_WAIT: begin
`ifdef JTCPS_BUSTIMEOUT_EN
               tout_q <= tout_q + 8'd1;
`endif
               if (bus.as_n) state_q <= ST_IDLE;
               else if (tout_hit) begin
                  state_q  <= ST_BERR;
`ifdef JTCPS_BUSTIMEOUT_EN
                  berr_n_q <= 1'b0;
`endif
               end else if (wait_q != 4'd0) wait_q <= wait_q - 4'd1;
               else if (ready) begin
                  state_q   <= ST_ACK;
                  dtack_n_q <= 1'b0;
               end
            end
            ST_ACK: if (bus.as_n) begin
               state_q   <= ST_IDLE;
               dtack_n_q <= 1'b1;
            end
            ST_BERR: if (bus.as_n) begin
               state_q  <= ST_IDLE;
`ifdef JTCPS_BUSTIMEOUT_EN
               berr_n_q <= 1'b1;
`endif
            end
            default: state_q <= ST_HOLD;
         endcase
      end
   end

   // Interrupt path runs on every clk, independent of the CPU clock enables.
   logic [NINT-1:0] irq_q;
   logic [NINT-1:0] pend_q;
   logic [NINT-1:0] pend_d;
   logic [NINT-1:0] clr;
   logic [NINT-1:0] rise;
   logic            iack_q;
   logic            ack_first;
   logic [2:0]      lvl_d;
   logic [2:0]      ipl_n_q;

   assign rise      = bus.irq & ~irq_q;
   assign ack_first = iack & ~iack_q;

   always_comb begin
      clr = '0;
      for (int i = 0; i < NINT; i++) clr[i] = ack_first && (bus.alvl == 3'(i + 1));
      // A new edge wins over an ack clear on the same level.
      pend_d = (pend_q & ~clr) | (rise & {NINT{bus.int_en}});
      lvl_d  = 3'd0;
      for (int i = 0; i < NINT; i++) if (pend_d[i]) lvl_d = 3'(i + 1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         irq_q   <= '0;
         iack_q  <= 1'b0;
         pend_q  <= '0;
         ipl_n_q <= 3'b111;
      end else begin
         irq_q   <= bus.irq;
         iack_q  <= iack;
         pend_q  <= pend_d;
         ipl_n_q <= ~lvl_d;
      end
   end

   assign bus.dtack_n = dtack_n_q;
   assign bus.vpa_n   = rst | ~iack;
   assign bus.ipl_n   = ipl_n_q;
`ifdef JTCPS_BUSTIMEOUT_EN
   assign bus.berr_n  = berr_n_q;
`else
   assign bus.berr_n  = 1'b1;
`endif
endmodule

// File: tb/tb_jtcps_busctl.sv
// Directed bench for jtcps_busctl: a WAIT=0 and a WAIT=2 instance share one stimulus set.
// Timeout checks follow JTCPS_BUSTIMEOUT_EN as the design does.
module tb_jtcps_busctl;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b0;
   logic       cenb = 1'b0;
   logic [1:0] ph = 2'd0;
   logic       as_n = 1'b1;
   logic [2:0] fc = 3'b101;
   logic [2:0] alvl = 3'd0;
   logic [1:0] cs = 2'b00;
   logic [1:0] ok = 2'b00;
   logic [1:0] irq = 2'b00;
   logic       int_en = 1'b1;

   int checks = 0;
   int errors = 0;

   jtcps_busctl_if #(.NCH(2), .NINT(2)) bus0 ();
   jtcps_busctl_if #(.NCH(2), .NINT(2)) bus2 ();

   assign bus0.cen = cen;   assign bus2.cen = cen;
   assign bus0.cenb = cenb; assign bus2.cenb = cenb;
   assign bus0.as_n = as_n; assign bus2.as_n = as_n;
   assign bus0.fc = fc;     assign bus2.fc = fc;
   assign bus0.alvl = alvl; assign bus2.alvl = alvl;
   assign bus0.cs = cs;     assign bus2.cs = cs;
   assign bus0.ok = ok;     assign bus2.ok = ok;
   assign bus0.irq = irq;   assign bus2.irq = irq;
   assign bus0.int_en = int_en; assign bus2.int_en = int_en;

   jtcps_busctl #(.NCH(2), .WAIT(0), .NINT(2), .TOUT(16)) u_w0 (.clk(clk), .rst(rst), .bus(bus0));
   jtcps_busctl #(.NCH(2), .WAIT(2), .NINT(2), .TOUT(16)) u_w2 (.clk(clk), .rst(rst), .bus(bus2));

   initial forever #5 clk = ~clk;

   // cen and cenb are one-clk pulses in opposite halves of a 4-clk CPU period.
   always @(negedge clk) begin
      ph   = ph + 2'd1;
      cen  = (ph == 2'd0);
      cenb = (ph == 2'd2);
   end

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_cenb();
      int n = 0;
      do begin
         @(posedge clk);
         n++;
      end while (!cenb && n < 16);
      #1;
      if (!cenb) check("cenb_timeout", 8'd0, 8'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      wait_clks(3);
      check("rst_dtack", bus0.dtack_n, 1'b1);
      check("rst_vpa",   bus0.vpa_n,   1'b1);
      check("rst_berr",  bus0.berr_n,  1'b1);
      check("rst_ipl",   bus0.ipl_n,   3'b111);
      rst = 1'b0;
      wait_cenb(); wait_cenb();

      // Zero-wait cycle, DTACKn held through an ok drop.
      cs = 2'b01; ok = 2'b01; as_n = 1'b0;
      wait_clks(1);
      check("s1_pre", bus0.dtack_n, 1'b1);
      wait_cenb();
      check("s1_ack", bus0.dtack_n, 1'b0);
      ok = 2'b00;
      wait_cenb();
      check("s1_hold", bus0.dtack_n, 1'b0);
      as_n = 1'b1;
      wait_clks(1);
      check("s1_as_unsampled", bus0.dtack_n, 1'b0);
      wait_cenb();
      check("s1_release", bus0.dtack_n, 1'b1);

      // No chip-select counts as ready.
      cs = 2'b00; ok = 2'b00; as_n = 1'b0;
      wait_cenb();
      check("cs_none", bus0.dtack_n, 1'b0);
      as_n = 1'b1;
      wait_cenb();

      // Two wait states, channel 1 ready on the 5th cenb.
      cs = 2'b10; ok = 2'b00; as_n = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         wait_cenb();
         check($sformatf("s2_wait%0d", k), bus2.dtack_n, 1'b1);
      end
      ok = 2'b10;
      wait_cenb();
      check("s2_ack", bus2.dtack_n, 1'b0);
      as_n = 1'b1;
      wait_cenb();
      check("s2_release", bus2.dtack_n, 1'b1);

      // Interrupt encoding and acknowledge.
      irq = 2'b11;
      wait_clks(3);
      check("s3_both", bus0.ipl_n, 3'b101);
      irq = 2'b00;
      fc = 3'b111; alvl = 3'd2; as_n = 1'b0;
      #1;
      check("s3_vpa_low", bus0.vpa_n, 1'b0);
      wait_clks(3);
      check("s3_ack2", bus0.ipl_n, 3'b110);
      wait_cenb(); wait_cenb();
      check("s3_no_dtack", bus0.dtack_n, 1'b1);
      as_n = 1'b1; fc = 3'b101;
      #1;
      check("s3_vpa_high", bus0.vpa_n, 1'b1);
      wait_cenb();
      fc = 3'b111; alvl = 3'd1; as_n = 1'b0;
      wait_clks(3);
      check("s3_ack1", bus0.ipl_n, 3'b111);
      as_n = 1'b1; fc = 3'b101;
      wait_cenb();

      // Out-of-range ack levels clear nothing.
      irq = 2'b01;
      wait_clks(3);
      irq = 2'b00;
      check("lvl1_set", bus0.ipl_n, 3'b110);
      fc = 3'b111; alvl = 3'd0; as_n = 1'b0;
      wait_clks(3);
      check("alvl0", bus0.ipl_n, 3'b110);
      as_n = 1'b1; fc = 3'b101;
      wait_clks(2);
      fc = 3'b111; alvl = 3'd3; as_n = 1'b0;
      wait_clks(3);
      check("alvl3", bus0.ipl_n, 3'b110);
      as_n = 1'b1; fc = 3'b101;
      wait_clks(2);

      // Ack clear and new edge on the same clk keep the level pending.
      fc = 3'b111; alvl = 3'd1; as_n = 1'b0; irq = 2'b01;
      wait_clks(3);
      check("ack_and_edge", bus0.ipl_n, 3'b110);
      as_n = 1'b1; fc = 3'b101; irq = 2'b00;
      wait_clks(2);
      fc = 3'b111; alvl = 3'd1; as_n = 1'b0;
      wait_clks(3);
      check("ack_clears", bus0.ipl_n, 3'b111);
      as_n = 1'b1; fc = 3'b101;
      wait_cenb();

      // Pause gating.
      int_en = 1'b0; irq = 2'b01;
      wait_clks(3);
      check("s4_masked", bus0.ipl_n, 3'b111);
      irq = 2'b00; int_en = 1'b1;
      wait_clks(2);
      check("s4_dropped", bus0.ipl_n, 3'b111);
      irq = 2'b01;
      wait_clks(3);
      check("s4_unmasked", bus0.ipl_n, 3'b110);
      irq = 2'b00; int_en = 1'b0;
      wait_clks(3);
      check("s4_retained", bus0.ipl_n, 3'b110);
      int_en = 1'b1;
      wait_cenb(); wait_cenb();

      // Bus timeout on a channel that never becomes ready.
      cs = 2'b01; ok = 2'b00; as_n = 1'b0;
`ifdef JTCPS_BUSTIMEOUT_EN
      for (int k = 1; k <= 15; k++) begin
         wait_cenb();
         check($sformatf("s5_berr_c%0d", k), bus0.berr_n, 1'b1);
      end
      wait_cenb();
      check("s5_berr_16", bus0.berr_n, 1'b0);
      check("s5_dtack_16", bus0.dtack_n, 1'b1);
      ok = 2'b01;
      wait_cenb();
      check("s5_berr_hold", bus0.berr_n, 1'b0);
      check("s5_dtack_supp", bus0.dtack_n, 1'b1);
      as_n = 1'b1;
      wait_cenb();
      check("s5_berr_release", bus0.berr_n, 1'b1);
`else
      repeat (20) wait_cenb();
      check("s5_berr_const", bus0.berr_n, 1'b1);
      check("s5_dtack_high", bus0.dtack_n, 1'b1);
      as_n = 1'b1;
      wait_cenb();
`endif
      wait_cenb();

      // Reset in the middle of a bus cycle.
      cs = 2'b01; ok = 2'b01; as_n = 1'b0;
      wait_cenb();
      check("s6_pre_w0", bus0.dtack_n, 1'b0);
      check("s6_pre_w2", bus2.dtack_n, 1'b1);
      rst = 1'b1;
      #1;
      check("s6_rst_dtack", bus0.dtack_n, 1'b1);
      check("s6_rst_ipl",   bus0.ipl_n,   3'b111);
      check("s6_rst_vpa",   bus0.vpa_n,   1'b1);
      wait_clks(2);
      rst = 1'b0;
      repeat (6) wait_cenb();
      check("s6_hold_w0", bus0.dtack_n, 1'b1);
      check("s6_hold_w2", bus2.dtack_n, 1'b1);
      as_n = 1'b1;
      wait_cenb();
      as_n = 1'b0;
      wait_cenb();
      check("s6_fresh_w0", bus0.dtack_n, 1'b0);
      check("s6_fresh_w2_early", bus2.dtack_n, 1'b1);
      repeat (3) wait_cenb();
      check("s6_fresh_w2", bus2.dtack_n, 1'b0);
      as_n = 1'b1;
      wait_cenb();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/jtcps_busctl.md
JTCPS_BUSCTL -- requirements
Module: jtcps_busctl

Interface
REQ-001 Parameter NCH, default 2: number of wait-capable memory channels (1..8).
REQ-002 Parameter WAIT, default 0: extra cenb cycles inserted before DTACKn on every bus cycle (0..15).
REQ-003 Parameter NINT, default 2: number of interrupt sources (1..7); source i drives level i+1.
REQ-004 Parameter TOUT, default 255: bus-timeout limit in cenb cycles (8-bit counter).
REQ-005 clk  in  1  system clock.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 cen  in  1  CPU phi1 clock enable.
REQ-008 cenb  in  1  CPU phi2 clock enable; all bus-cycle logic advances on it.
REQ-009 ASn  in  1  68000 address strobe.
REQ-010 FC  in  3  68000 function code.
REQ-011 alvl  in  3  CPU A[3:1], the level under acknowledge.
REQ-012 cs  in  NCH  channel chip-selects, valid while ASn is low.
REQ-013 ok  in  NCH  channel data-ready flags.
REQ-014 irq  in  NINT  interrupt sources; a rising edge requests.
REQ-015 int_en  in  1  high accepts new requests (pause gating).
REQ-016 DTACKn  out  1  data acknowledge.
REQ-017 VPAn  out  1  autovector request.
REQ-018 BERRn  out  1  bus error.
REQ-019 IPLn  out  3  encoded interrupt priority, active low.

Function
REQ-020 Cycle start: ASn sampled low on a cenb after being high; wait counter loads WAIT.
REQ-021 Wait counter decrements once per cenb while ASn low and counter is non-zero.
REQ-022 DTACKn goes low on the first cenb with ASn low, counter 0, and ok[k]=1 for every k with cs[k]=1; cs all zero counts as ready.
REQ-023 With WAIT=0 and ready, DTACKn falls on the cenb that samples the cycle start (1 cenb latency).
REQ-024 Once low, DTACKn stays low even if ok drops; it returns high on the first cenb sampling ASn high.
REQ-025 Interrupt-ack cycles (FC=3'b111, ASn low) never assert DTACKn.
REQ-026 Interrupt-ack cycles assert VPAn low combinationally, and VPAn returns high with ASn.
REQ-027 Edge detection: irq is registered on clk. A rising edge with int_en=1 sets pending[i]. With int_en=0 the edge is dropped and existing pending bits are retained.
REQ-028 IPLn is the complement of the highest pending level; it is 3'b111 when nothing is pending. It is registered on clk.
REQ-029 Ack clear: on the first clk of an ack cycle, pending[alvl-1] clears. Only that level clears; lower levels stay pending.
REQ-030 Simultaneous ack clear and new edge on the same level: pending stays 1.
REQ-031 alvl=0, or alvl>NINT, during an ack clears nothing.

Reset
REQ-032 While rst is high, all of the following are forced regardless of enables: DTACKn=1, VPAn=1, BERRn=1, IPLn=3'b111, pending=0, wait counter=0, timeout counter=0, edge registers=0.
REQ-033 Reset mid-cycle returns outputs to idle at once.
REQ-034 After reset release with ASn still low, no DTACKn is issued until a fresh ASn high-to-low transition.

Configuration
REQ-035 Macro JTCPS_BUSTIMEOUT_EN defined: a timeout counter counts cenb cycles while ASn is low and DTACKn is high.
REQ-036 With the macro, reaching TOUT drives BERRn low until ASn is sampled high. DTACKn is suppressed for that cycle, and the counter clears at every cycle start.
REQ-037 Macro undefined: BERRn is constant 1 and no timeout logic is synthesised.

Verification
REQ-038 Scenario 1. Setup: WAIT=0, cs=01, ok=1, ASn falls. Required: DTACKn low on the next cenb; high one cenb after ASn rises.
REQ-039 Scenario 2. Setup: WAIT=2, cs=10, ok[1] rising 5 cenb after ASn falls. Required: DTACKn low on that 5th cenb, not earlier.
REQ-040 Scenario 3. Setup: NINT=2, irq[0] and irq[1] edges. Required: IPLn=3'b101. Ack with alvl=2 gives VPAn low and then IPLn=3'b110; ack with alvl=1 then gives IPLn=3'b111.
REQ-041 Scenario 4. Setup: int_en=0, irq[0] edge. Required: IPLn stays 3'b111. Then int_en=1 and a new edge gives IPLn=3'b110.
REQ-042 Scenario 5. Setup: JTCPS_BUSTIMEOUT_EN, TOUT=16, cs=01, ok=0. Required: BERRn low on the 16th cenb, DTACKn stays high, BERRn high after ASn rises.
REQ-043 Scenario 6. Setup: rst pulse during a wait state. Required: DTACKn=1 and IPLn=3'b111 immediately; no DTACKn until ASn toggles.
